// File: rtl/k580vt57.sv
// k580vt57: 4-channel DMA controller (8257-class) in the CPU clock domain.
// The controller arbitrates channel requests and takes the bus via hrq/hlda.
// It then drives the address, dack and the memory/IO strobes.
// It carries no data: memory and I/O exchange bytes directly.
// Optional feature: define K580VT57_AUTOLOAD_EN to enable ch2 autoload from ch3.
module k580vt57 #(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  iaddr,
    input  logic [7:0]  idata,
    output logic [7:0]  odata,
    input  logic        iwe_n,
    input  logic        ird_n,
    input  logic [3:0]  drq,
    output logic [3:0]  dack,
    output logic        hrq,
    input  logic        hlda,
    output logic [15:0] oaddr,
    output logic        memr,
    output logic        memw,
    output logic        ior,
    output logic        iow,
    output logic        tc
);

    typedef enum logic [2:0] {StIdle, StWait, StS1, StS2, StS3} state_e;

    localparam logic [1:0] S2Last = 2'(STROBE_CYCLES - 1);

    logic [15:0] addr_q [4];
    logic [15:0] cnt_q  [4];   // [15:14] transfer type, [13:0] count
    logic [7:0]  mode_q;
    logic        ff_q;
    logic [3:0]  tc_flag_q;
    logic        update_q;
    state_e      state_q, state_d;
    logic [1:0]  ch_q, typ_q, rot_q, s2_cnt_q;
    logic        last_q;       // current transfer is the terminal-count byte
    logic        iwe_n_q, ird_n_q;

    logic        we_edge, rd_edge;
    logic [3:0]  req;
    logic        any_req;
    logic        ext_wr;
    logic        autoload;
    logic [1:0]  base, idx, win, win_typ;
    logic        win_last;
    logic [15:0] rd_word;
    logic [3:0]  wr_mask;

    assign we_edge = iwe_n & ~iwe_n_q;
    assign rd_edge = ird_n & ~ird_n_q;
    assign req     = drq & mode_q[3:0];
    assign any_req = |req;
    assign ext_wr  = mode_q[5];

`ifdef K580VT57_AUTOLOAD_EN
    assign autoload = mode_q[7];
`else
    // mode[7] is stored but inert in this build
    logic unused_autoload_bit;
    assign unused_autoload_bit = mode_q[7];
    assign autoload = 1'b0;
`endif

    // Arbitration: search from the priority base upward, first hit wins
    always_comb begin
        base = mode_q[4] ? rot_q : 2'd0;
        win  = base;
        idx  = base;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req[idx]) win = idx;
        end
        win_typ  = cnt_q[win][15:14];
        win_last = (cnt_q[win][13:0] == 14'd0);
    end

    // Channels written by a CPU access; ch2 writes mirror into ch3 under autoload
    always_comb begin
        wr_mask = 4'(1) << iaddr[2:1];
        if (autoload && iaddr[2:1] == 2'd2) wr_mask[3] = 1'b1;
    end

    // CPU read mux, returns live register values
    always_comb begin
        odata   = 8'h00;
        rd_word = iaddr[0] ? cnt_q[iaddr[2:1]] : addr_q[iaddr[2:1]];
        if (!iaddr[3]) begin
            odata = ff_q ? rd_word[15:8] : rd_word[7:0];
        end else if (iaddr == 4'd8) begin
            odata = {3'b000, update_q, tc_flag_q};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (any_req) state_d = StWait;
            StWait: if (hlda) state_d = any_req ? StS1 : StIdle;
            StS1:   state_d = StS2;
            StS2:   if (s2_cnt_q == S2Last) state_d = StS3;
            StS3:   state_d = (any_req && hlda) ? StWait : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // CPU register port and transfer datapath; FSM updates come last so they win
    always_ff @(posedge clk) begin
        if (reset) begin
            hrq       <= 1'b0;
            dack      <= 4'b0000;
            memr      <= 1'b0;
            memw      <= 1'b0;
            ior       <= 1'b0;
            iow       <= 1'b0;
            tc        <= 1'b0;
            oaddr     <= 16'h0000;
            mode_q    <= 8'h00;
            ff_q      <= 1'b0;
            tc_flag_q <= 4'b0000;
            update_q  <= 1'b0;
            rot_q     <= 2'd0;
            ch_q      <= 2'd0;
            typ_q     <= 2'd0;
            s2_cnt_q  <= 2'd0;
            last_q    <= 1'b0;
            iwe_n_q   <= 1'b1;
            ird_n_q   <= 1'b1;
        end else begin
            iwe_n_q <= iwe_n;
            ird_n_q <= ird_n;

            if (we_edge) begin
                if (!iaddr[3]) begin
                    for (int c = 0; c < 4; c++) begin
                        if (wr_mask[c]) begin
                            if (iaddr[0]) begin
                                if (ff_q) cnt_q[c][15:8] <= idata;
                                else      cnt_q[c][7:0]  <= idata;
                            end else begin
                                if (ff_q) addr_q[c][15:8] <= idata;
                                else      addr_q[c][7:0]  <= idata;
                            end
                        end
                    end
                    ff_q <= ~ff_q;
                end else if (iaddr == 4'd8) begin
                    mode_q <= idata;
                    ff_q   <= 1'b0;
                    rot_q  <= 2'd0;
                end
            end else if (rd_edge) begin
                if (!iaddr[3]) begin
                    ff_q <= ~ff_q;
                end else if (iaddr == 4'd8) begin
                    tc_flag_q <= 4'b0000;
                    update_q  <= 1'b0;
                end
            end

            case (state_q)
                StIdle: begin
                    if (any_req) hrq <= 1'b1;
                end
                StWait: begin
                    if (hlda) begin
                        if (any_req) begin
                            ch_q   <= win;
                            typ_q  <= win_typ;
                            oaddr  <= addr_q[win];
                            dack   <= 4'(1) << win;
                            tc     <= win_last;
                            last_q <= win_last;
                            // read-side strobes now; write-side early only with extended write
                            memr   <= (win_typ == 2'b10);
                            ior    <= (win_typ == 2'b01);
                            iow    <= ext_wr && (win_typ == 2'b10);
                            memw   <= ext_wr && (win_typ == 2'b01);
                        end else begin
                            hrq <= 1'b0;
                        end
                    end
                end
                StS1: begin
                    iow      <= (typ_q == 2'b10);
                    memw     <= (typ_q == 2'b01);
                    s2_cnt_q <= 2'd0;
                end
                StS2: begin
                    if (s2_cnt_q == S2Last) begin
                        memr <= 1'b0;
                        memw <= 1'b0;
                        ior  <= 1'b0;
                        iow  <= 1'b0;
                        dack <= 4'b0000;
                        tc   <= 1'b0;
                    end else begin
                        s2_cnt_q <= s2_cnt_q + 2'd1;
                    end
                end
                StS3: begin
                    addr_q[ch_q] <= addr_q[ch_q] + 16'd1;
                    cnt_q[ch_q]  <= {cnt_q[ch_q][15:14], cnt_q[ch_q][13:0] - 14'd1};
                    rot_q        <= ch_q + 2'd1;
                    hrq          <= any_req && hlda;
                    if (last_q) begin
                        tc_flag_q[ch_q] <= 1'b1;
                        if (autoload && ch_q == 2'd2) begin
                            addr_q[2] <= addr_q[3];
                            cnt_q[2]  <= cnt_q[3];
                            update_q  <= 1'b1;
                        end else if (mode_q[6]) begin
                            mode_q[{1'b0, ch_q}] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_k580vt57.sv
// tb_k580vt57: directed bench for the k580vt57 DMA controller.
// Expected transfers are queued as stimulus is issued; a monitor captures each
// dack window (address, tc, strobe cycle counts) and compares it in order.
module tb_k580vt57;

    localparam int unsigned SC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  iaddr = 4'd0;
    logic [7:0]  idata = 8'd0;
    logic        iwe_n = 1'b1;
    logic        ird_n = 1'b1;
    logic [3:0]  drq = 4'd0;
    logic        hlda = 1'b0;
    logic [7:0]  odata;
    logic [3:0]  dack;
    logic        hrq;
    logic [15:0] oaddr;
    logic        memr, memw, ior, iow, tc;

    int checks = 0;
    int errors = 0;
    int done_xfers = 0;

    typedef struct packed {
        logic [3:0]  dack;
        logic [15:0] addr;
        logic        tc;
        logic [7:0]  memr;
        logic [7:0]  memw;
        logic [7:0]  ior;
        logic [7:0]  iow;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t cur, expd;
    logic  active = 1'b0;

    k580vt57 #(.STROBE_CYCLES(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .iaddr (iaddr),
        .idata (idata),
        .odata (odata),
        .iwe_n (iwe_n),
        .ird_n (ird_n),
        .drq   (drq),
        .dack  (dack),
        .hrq   (hrq),
        .hlda  (hlda),
        .oaddr (oaddr),
        .memr  (memr),
        .memw  (memw),
        .ior   (ior),
        .iow   (iow),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    // CPU grants the bus one cycle after it is requested
    always @(negedge clk) hlda = hrq;

    // Monitor: accumulate one dack window, compare when it closes
    always @(negedge clk) begin
        if (reset) begin
            active = 1'b0;
        end else if (dack != 4'd0) begin
            if (!active) begin
                active   = 1'b1;
                cur      = '0;
                cur.dack = dack;
                cur.addr = oaddr;
            end
            cur.tc   = cur.tc | tc;
            cur.memr = cur.memr + 8'(memr);
            cur.memw = cur.memw + 8'(memw);
            cur.ior  = cur.ior + 8'(ior);
            cur.iow  = cur.iow + 8'(iow);
        end else if (active) begin
            active = 1'b0;
            checks++;
            done_xfers++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got dack=%b addr=%h, required none", cur.dack,
                         cur.addr);
            end else begin
                expd = exp_q.pop_front();
                if (cur !== expd) begin
                    errors++;
                    $display("FAIL xfer: got dack=%b addr=%h tc=%b r/w/ior/iow=%0d/%0d/%0d/%0d, required dack=%b addr=%h tc=%b r/w/ior/iow=%0d/%0d/%0d/%0d",
                             cur.dack, cur.addr, cur.tc, cur.memr, cur.memw, cur.ior, cur.iow,
                             expd.dack, expd.addr, expd.tc, expd.memr, expd.memw, expd.ior,
                             expd.iow);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        iaddr = a;
        idata = d;
        iwe_n = 1'b0;
        @(negedge clk);
        iwe_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr16(input logic [3:0] a, input logic [15:0] d);
        wr(a, d[7:0]);
        wr(a, d[15:8]);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        iaddr = a;
        ird_n = 1'b0;
        @(negedge clk);
        d = odata;
        ird_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd16(input logic [3:0] a, output logic [15:0] d);
        logic [7:0] lo, hi;
        rd(a, lo);
        rd(a, hi);
        d = {hi, lo};
    endtask

    // Type 10 = memr+iow, type 01 = ior+memw; counts assume SC strobe cycles in S2
    task automatic push(input logic [3:0] dk, input logic [15:0] a, input logic t,
                        input logic [1:0] typ, input logic ext);
        xfer_t x;
        x      = '0;
        x.dack = dk;
        x.addr = a;
        x.tc   = t;
        if (typ == 2'b10) begin
            x.memr = 8'(SC + 1);
            x.iow  = ext ? 8'(SC + 1) : 8'(SC);
        end else if (typ == 2'b01) begin
            x.ior  = 8'(SC + 1);
            x.memw = ext ? 8'(SC + 1) : 8'(SC);
        end
        exp_q.push_back(x);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        tick(4);
        for (int i = 0; i < budget; i++) begin
            if (hrq == 1'b0 && dack == 4'd0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, 16'(ok), 16'd1);
    endtask

    initial begin
        logic [7:0]  v;
        logic [15:0] w;
        int          n0;
        bit          ok;

        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  v;
        logic [15:0] w;
        int          n0;
        bit          ok;

        // Reset state
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_hrq", 16'(hrq), 16'd0);
        check("rst_dack", 16'(dack), 16'd0);
        check("rst_strobes", 16'({memr, memw, ior, iow, tc}), 16'd0);
        check("rst_oaddr", oaddr, 16'h0000);
        rd(4'd8, v);
        check("rst_status", 16'(v), 16'h0000);

        // ch1 read-from-memory, 3 bytes, TC-stop
        wr(4'd8, 8'h00);
        wr16(4'd2, 16'h1234);
        wr16(4'd3, 16'h8002);
        push(4'b0010, 16'h1234, 1'b0, 2'b10, 1'b0);
        push(4'b0010, 16'h1235, 1'b0, 2'b10, 1'b0);
        push(4'b0010, 16'h1236, 1'b1, 2'b10, 1'b0);
        wr(4'd8, 8'h42);
        drq = 4'b0010;
        wait_idle("t1_idle", 300);
        tick(10);
        check("t1_en_cleared_hrq", 16'(hrq), 16'd0);
        drq = 4'b0000;
        check("t1_drain", 16'(exp_q.size()), 16'd0);
        rd(4'd8, v);
        check("t1_status", 16'(v), 16'h0002);
        rd(4'd8, v);
        check("t1_status_reread", 16'(v), 16'h0000);

        // Fixed priority: ch0 before ch3
        wr(4'd8, 8'h00);
        wr16(4'd0, 16'h0100);
        wr16(4'd1, 16'h8000);
        wr16(4'd6, 16'h0300);
        wr16(4'd7, 16'h8000);
        push(4'b0001, 16'h0100, 1'b1, 2'b10, 1'b0);
        push(4'b1000, 16'h0300, 1'b1, 2'b10, 1'b0);
        wr(4'd8, 8'h49);
        drq = 4'b1001;
        wait_idle("t2_idle", 300);
        drq = 4'b0000;
        check("t2_drain", 16'(exp_q.size()), 16'd0);
        rd(4'd8, v);
        check("t2_status", 16'(v), 16'h0009);

        // Rotating priority: ch0 and ch3 alternate
        wr(4'd8, 8'h00);
        wr16(4'd0, 16'h0200);
        wr16(4'd1, 16'h8003);
        wr16(4'd6, 16'h0A00);
        wr16(4'd7, 16'h8003);
        for (int i = 0; i < 4; i++) begin
            push(4'b0001, 16'h0200 + 16'(i), i == 3, 2'b10, 1'b0);
            push(4'b1000, 16'h0A00 + 16'(i), i == 3, 2'b10, 1'b0);
        end
        wr(4'd8, 8'h59);
        drq = 4'b1001;
        wait_idle("t3_idle", 600);
        drq = 4'b0000;
        check("t3_drain", 16'(exp_q.size()), 16'd0);
        rd(4'd8, v);
        check("t3_status", 16'(v), 16'h0009);

        // Write-to-memory, extended write off then on
        wr(4'd8, 8'h00);
        wr16(4'd2, 16'h4000);
        wr16(4'd3, 16'h4000);
        push(4'b0010, 16'h4000, 1'b1, 2'b01, 1'b0);
        wr(4'd8, 8'h42);
        drq = 4'b0010;
        wait_idle("t4_idle_noext", 300);
        drq = 4'b0000;
        wr(4'd8, 8'h00);
        wr16(4'd2, 16'h5000);
        wr16(4'd3, 16'h4000);
        push(4'b0010, 16'h5000, 1'b1, 2'b01, 1'b1);
        wr(4'd8, 8'h62);
        drq = 4'b0010;
        wait_idle("t4_idle_ext", 300);
        drq = 4'b0000;
        check("t4_drain", 16'(exp_q.size()), 16'd0);
        rd(4'd8, v);
        check("t4_status", 16'(v), 16'h0002);

        // Byte flip-flop cleared by mode write
        wr(4'd8, 8'h00);
        wr16(4'd0, 16'h1111);
        wr(4'd0, 8'hCD);
        wr(4'd8, 8'h00);
        wr(4'd0, 8'hAB);
        wr(4'd8, 8'h00);
        rd16(4'd0, w);
        check("t5_ff_clear", w, 16'h11AB);

        // ch2 with mode[7]: autoload from ch3 only when the feature is built in
        wr(4'd8, 8'h00);
        wr16(4'd6, 16'h9999);
        wr(4'd8, 8'h80);
        wr16(4'd4, 16'h76D0);
        wr16(4'd5, 16'h4003);
        for (int i = 0; i < 4; i++) push(4'b0100, 16'h76D0 + 16'(i), i == 3, 2'b01, 1'b0);
`ifdef K580VT57_AUTOLOAD_EN
        push(4'b0100, 16'h76D0, 1'b0, 2'b01, 1'b0);
`endif
        wr(4'd8, 8'hC4);
        n0 = done_xfers;
        drq = 4'b0100;
`ifdef K580VT57_AUTOLOAD_EN
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_xfers >= n0 + 4 && dack != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_fifth_start", 16'(ok), 16'd1);
        drq = 4'b0000;
        wait_idle("t6_idle", 100);
`else
        wait_idle("t6_idle", 400);
        tick(10);
        check("t6_en_cleared_hrq", 16'(hrq), 16'd0);
        drq = 4'b0000;
`endif
        check("t6_drain", 16'(exp_q.size()), 16'd0);
        rd(4'd8, v);
`ifdef K580VT57_AUTOLOAD_EN
        check("t6_status", 16'(v), 16'h0014);
        rd16(4'd6, w);
        check("t6_ch3_addr", w, 16'h76D0);
        rd16(4'd4, w);
        check("t6_ch2_addr", w, 16'h76D1);
`else
        check("t6_status", 16'(v), 16'h0004);
        rd16(4'd6, w);
        check("t6_ch3_addr", w, 16'h9999);
        rd16(4'd4, w);
        check("t6_ch2_addr", w, 16'h76D4);
`endif

        // Reset asserted during S2
        wr(4'd8, 8'h00);
        wr16(4'd2, 16'h2000);
        wr16(4'd3, 16'h8000);
        wr(4'd8, 8'h02);
        drq = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (iow) begin
                ok = 1'b1;
                break;
            end
        end
        check("t7_reach_s2", 16'(ok), 16'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t7_dack", 16'(dack), 16'd0);
        check("t7_strobes", 16'({memr, memw, ior, iow}), 16'd0);
        check("t7_hrq", 16'(hrq), 16'd0);
        reset = 1'b0;
        tick(10);
        check("t7_mode_cleared_hrq", 16'(hrq), 16'd0);
        drq = 4'b0000;
        rd(4'd8, v);
        check("t7_status", 16'(v), 16'h0000);
        check("final_drain", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
